// File: rtl/iob_ext_dp_arbiter_if.sv
// Two IOb-native requesters and one Versat ext_dp RAM port, bundled for the arbiter.
// slave = arbiter view, master = environment (requesters + RAM) view.
interface iob_ext_dp_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              m0_iob_valid_i;
  logic [ADDR_W-1:0] m0_iob_addr_i;
  logic [DATA_W-1:0] m0_iob_wdata_i;
  logic [STRB_W-1:0] m0_iob_wstrb_i;
  logic              m0_iob_ready_o;
  logic              m0_iob_rvalid_o;
  logic [DATA_W-1:0] m0_iob_rdata_o;

  logic              m1_iob_valid_i;
  logic [ADDR_W-1:0] m1_iob_addr_i;
  logic [DATA_W-1:0] m1_iob_wdata_i;
  logic [STRB_W-1:0] m1_iob_wstrb_i;
  logic              m1_iob_ready_o;
  logic              m1_iob_rvalid_o;
  logic [DATA_W-1:0] m1_iob_rdata_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_out_o;
  logic [DATA_W-1:0] mem_in_i;
  logic              mem_enable_o;
  logic              mem_write_o;

  modport slave (
    input  m0_iob_valid_i, m0_iob_addr_i, m0_iob_wdata_i, m0_iob_wstrb_i,
    output m0_iob_ready_o, m0_iob_rvalid_o, m0_iob_rdata_o,
    input  m1_iob_valid_i, m1_iob_addr_i, m1_iob_wdata_i, m1_iob_wstrb_i,
    output m1_iob_ready_o, m1_iob_rvalid_o, m1_iob_rdata_o,
    output mem_addr_o, mem_out_o, mem_enable_o, mem_write_o,
    input  mem_in_i
  );

  modport master (
    output m0_iob_valid_i, m0_iob_addr_i, m0_iob_wdata_i, m0_iob_wstrb_i,
    input  m0_iob_ready_o, m0_iob_rvalid_o, m0_iob_rdata_o,
    output m1_iob_valid_i, m1_iob_addr_i, m1_iob_wdata_i, m1_iob_wstrb_i,
    input  m1_iob_ready_o, m1_iob_rvalid_o, m1_iob_rdata_o,
    input  mem_addr_o, mem_out_o, mem_enable_o, mem_write_o,
    output mem_in_i
  );
endinterface

// File: rtl/iob_ext_dp_arbiter.sv
// Round-robin arbiter sharing one ext_dp RAM port between two IOb masters,
// with bounded bursts and read-modify-write for byte-strobed writes.
module iob_ext_dp_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                 clk_i,
  input logic                 arst_n_i,
  iob_ext_dp_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {ST_ARB = 1'b0, ST_MERGE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [STRB_W-1:0] lat_wstrb_q, lat_wstrb_d;

  logic              contested;
  logic              win;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;

  logic              ready0_c, ready1_c;
  logic              mem_en_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_out_c;

  // Winner: the lone requester, or prio when both ask.
  assign contested = bus.m0_iob_valid_i & bus.m1_iob_valid_i;
  assign win       = contested ? prio_q : bus.m1_iob_valid_i;
  assign w_addr    = win ? bus.m1_iob_addr_i  : bus.m0_iob_addr_i;
  assign w_wdata   = win ? bus.m1_iob_wdata_i : bus.m0_iob_wdata_i;
  assign w_wstrb   = win ? bus.m1_iob_wstrb_i : bus.m0_iob_wstrb_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= ST_ARB;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      rv0_q       <= rv0_d;
      rv1_q       <= rv1_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_wstrb_q <= lat_wstrb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    rv0_d       = 1'b0;
    rv1_d       = 1'b0;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_wstrb_d = lat_wstrb_q;
    ready0_c    = 1'b0;
    ready1_c    = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_out_c   = '0;

    case (state_q)
      ST_ARB: begin
        if (bus.m0_iob_valid_i | bus.m1_iob_valid_i) begin
          ready0_c   = ~win;
          ready1_c   = win;
          mem_en_c   = 1'b1;
          mem_addr_c = w_addr;
          if (w_wstrb == '0) begin
            rv0_d = ~win;
            rv1_d = win;
          end else if (&w_wstrb) begin
            mem_we_c  = 1'b1;
            mem_out_c = w_wdata;
          end else begin
            // Partial write: this cycle reads the old word, MERGE writes it back.
            lat_addr_d  = w_addr;
            lat_wdata_d = w_wdata;
            lat_wstrb_d = w_wstrb;
            state_d     = ST_MERGE;
          end
          if (contested) begin
            if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
              prio_d = ~win;
              cnt_d  = '0;
            end else begin
              prio_d = win;
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end else begin
            prio_d = win;
            cnt_d  = '0;
          end
        end
      end
      ST_MERGE: begin
        mem_en_c   = 1'b1;
        mem_we_c   = 1'b1;
        mem_addr_c = lat_addr_q;
        for (int unsigned i = 0; i < STRB_W; i++) begin
          mem_out_c[8*i +: 8] = lat_wstrb_q[i] ? lat_wdata_q[8*i +: 8] : bus.mem_in_i[8*i +: 8];
        end
        state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted.
  assign bus.m0_iob_ready_o  = arst_n_i & ready0_c;
  assign bus.m1_iob_ready_o  = arst_n_i & ready1_c;
  assign bus.mem_enable_o    = arst_n_i & mem_en_c;
  assign bus.mem_write_o     = arst_n_i & mem_we_c;
  assign bus.mem_addr_o      = arst_n_i ? mem_addr_c : '0;
  assign bus.mem_out_o       = arst_n_i ? mem_out_c  : '0;

  assign bus.m0_iob_rvalid_o = rv0_q;
  assign bus.m1_iob_rvalid_o = rv1_q;
  assign bus.m0_iob_rdata_o  = rv0_q ? bus.mem_in_i : '0;
  assign bus.m1_iob_rdata_o  = rv1_q ? bus.mem_in_i : '0;
endmodule

// File: tb/tb_iob_ext_dp_arbiter.sv
// Bench: two arbiters (MAX_BURST=4 and MAX_BURST=1) on identical stimulus, each
// with its own RAM; directed table, corner sequences and random traffic vs a model.
module tb_iob_ext_dp_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        v0, v1;
  logic [11:0] a0, a1;
  logic [31:0] wd0, wd1;
  logic [3:0]  ws0, ws1;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  iob_ext_dp_arbiter_if #(.ADDR_W(12), .DATA_W(32)) if4 ();
  iob_ext_dp_arbiter_if #(.ADDR_W(12), .DATA_W(32)) if1 ();

  iob_ext_dp_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(4)) u_dut4 (
    .clk_i(clk), .arst_n_i(rst_n), .bus(if4));
  iob_ext_dp_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(1)) u_dut1 (
    .clk_i(clk), .arst_n_i(rst_n), .bus(if1));

  assign if4.m0_iob_valid_i = v0;  assign if1.m0_iob_valid_i = v0;
  assign if4.m0_iob_addr_i  = a0;  assign if1.m0_iob_addr_i  = a0;
  assign if4.m0_iob_wdata_i = wd0; assign if1.m0_iob_wdata_i = wd0;
  assign if4.m0_iob_wstrb_i = ws0; assign if1.m0_iob_wstrb_i = ws0;
  assign if4.m1_iob_valid_i = v1;  assign if1.m1_iob_valid_i = v1;
  assign if4.m1_iob_addr_i  = a1;  assign if1.m1_iob_addr_i  = a1;
  assign if4.m1_iob_wdata_i = wd1; assign if1.m1_iob_wdata_i = wd1;
  assign if4.m1_iob_wstrb_i = ws1; assign if1.m1_iob_wstrb_i = ws1;

  // RAM models: 1-cycle read latency, write-then-read ordered.
  logic [31:0] ram4 [4096];
  logic [31:0] ram1 [4096];
  logic [31:0] rd4, rd1;
  always @(posedge clk) begin
    if (pre_en) ram4[pre_addr] <= pre_data;
    else if (if4.mem_enable_o) begin
      if (if4.mem_write_o) ram4[if4.mem_addr_o] <= if4.mem_out_o;
      else rd4 <= ram4[if4.mem_addr_o];
    end
  end
  always @(posedge clk) begin
    if (pre_en) ram1[pre_addr] <= pre_data;
    else if (if1.mem_enable_o) begin
      if (if1.mem_write_o) ram1[if1.mem_addr_o] <= if1.mem_out_o;
      else rd1 <= ram1[if1.mem_addr_o];
    end
  end
  assign if4.mem_in_i = rd4;
  assign if1.mem_in_i = rd1;

  // Reference model state: k=0 is the MAX_BURST=4 instance, k=1 the MAX_BURST=1 one.
  logic [31:0] sh [2][4096];
  int          m_prio [2];
  int          m_run  [2];
  bit          m_busy [2];
  logic [11:0] m_baddr[2];
  logic [31:0] m_bdata[2];
  logic [1:0]  m_rv   [2];
  logic [31:0] m_rdata[2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic get_out(input int k, output logic [1:0] rdy, output logic [1:0] rv,
                         output logic [31:0] rdat0, output logic [31:0] rdat1,
                         output logic en, output logic we,
                         output logic [31:0] mout, output logic [11:0] maddr);
    if (k == 0) begin
      rdy = {if4.m1_iob_ready_o, if4.m0_iob_ready_o};
      rv  = {if4.m1_iob_rvalid_o, if4.m0_iob_rvalid_o};
      rdat0 = if4.m0_iob_rdata_o; rdat1 = if4.m1_iob_rdata_o;
      en = if4.mem_enable_o; we = if4.mem_write_o;
      mout = if4.mem_out_o; maddr = if4.mem_addr_o;
    end else begin
      rdy = {if1.m1_iob_ready_o, if1.m0_iob_ready_o};
      rv  = {if1.m1_iob_rvalid_o, if1.m0_iob_rvalid_o};
      rdat0 = if1.m0_iob_rdata_o; rdat1 = if1.m1_iob_rdata_o;
      en = if1.mem_enable_o; we = if1.mem_write_o;
      mout = if1.mem_out_o; maddr = if1.mem_addr_o;
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prio[k] = 0; m_run[k] = 0; m_busy[k] = 1'b0; m_rv[k] = 2'b00; m_rdata[k] = '0;
    end
  endtask

  // Compare one instance against the transaction-level model, then advance the model.
  task automatic model_step(input int k);
    logic [1:0] rdy, rv, e_rdy;
    logic [31:0] rdat0, rdat1, mout;
    logic [11:0] maddr, addr;
    logic en, we;
    logic [31:0] wd;
    logic [3:0] ws;
    int w, maxb;
    bit contested;
    maxb = (k == 0) ? 4 : 1;
    get_out(k, rdy, rv, rdat0, rdat1, en, we, mout, maddr);
    contested = v0 && v1;
    w = -1;
    if (!m_busy[k]) begin
      if (contested) w = m_prio[k];
      else if (v0) w = 0;
      else if (v1) w = 1;
    end
    e_rdy = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    chk($sformatf("model%0d ready", k), 128'(rdy), 128'(e_rdy));
    chk($sformatf("model%0d rvalid", k), 128'(rv), 128'(m_rv[k]));
    chk($sformatf("model%0d rdata0", k), 128'(rdat0), 128'(m_rv[k][0] ? m_rdata[k] : 32'h0));
    chk($sformatf("model%0d rdata1", k), 128'(rdat1), 128'(m_rv[k][1] ? m_rdata[k] : 32'h0));
    m_rv[k] = 2'b00;
    if (m_busy[k]) begin
      sh[k][m_baddr[k]] = m_bdata[k];
      m_busy[k] = 1'b0;
    end else if (w >= 0) begin
      addr = (w == 0) ? a0 : a1;
      wd   = (w == 0) ? wd0 : wd1;
      ws   = (w == 0) ? ws0 : ws1;
      if (ws == 4'h0) begin
        m_rv[k] = (w == 0) ? 2'b01 : 2'b10;
        m_rdata[k] = sh[k][addr];
      end else if (ws == 4'hF) begin
        sh[k][addr] = wd;
      end else begin
        m_busy[k] = 1'b1; m_baddr[k] = addr; m_bdata[k] = merge(sh[k][addr], wd, ws);
      end
      if (contested) begin
        m_run[k]++;
        if (m_run[k] >= maxb) begin m_prio[k] = 1 - w; m_run[k] = 0; end
        else m_prio[k] = w;
      end else begin
        m_prio[k] = w; m_run[k] = 0;
      end
    end
  endtask

  // Called at the falling edge: model checks, then move to just after the next rising edge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(negedge clk);
    tick();
  endtask

  task automatic idle();
    v0 = 1'b0; a0 = '0; wd0 = '0; ws0 = '0;
    v1 = 1'b0; a1 = '0; wd1 = '0; ws1 = '0;
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    idle();
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    sh[0][addr] = data; sh[1][addr] = data;
    step();
    pre_en = 1'b0;
  endtask

  task automatic chk_zero(input int k, input string tag);
    logic [1:0] rdy, rv;
    logic [31:0] rdat0, rdat1, mout;
    logic [11:0] maddr;
    logic en, we;
    get_out(k, rdy, rv, rdat0, rdat1, en, we, mout, maddr);
    chk($sformatf("%s dut%0d outputs", tag, k),
        128'({rdy, rv, rdat0, rdat1, en, we, mout, maddr}), 128'h0);
  endtask

  typedef struct {
    logic v0; logic [11:0] a0; logic [31:0] wd0; logic [3:0] ws0;
    logic v1; logic [11:0] a1; logic [31:0] wd1; logic [3:0] ws1;
    logic [1:0] rdy; logic [1:0] rv; logic [31:0] rdata;
    logic en; logic we; logic [31:0] mout;
  } vec_t;

  function automatic vec_t mk(input logic v0_, input logic [11:0] a0_, input logic [31:0] wd0_,
                              input logic [3:0] ws0_, input logic v1_, input logic [11:0] a1_,
                              input logic [31:0] wd1_, input logic [3:0] ws1_,
                              input logic [1:0] rdy_, input logic [1:0] rv_,
                              input logic [31:0] rdata_, input logic en_, input logic we_,
                              input logic [31:0] mout_);
    vec_t r;
    r.v0 = v0_; r.a0 = a0_; r.wd0 = wd0_; r.ws0 = ws0_;
    r.v1 = v1_; r.a1 = a1_; r.wd1 = wd1_; r.ws1 = ws1_;
    r.rdy = rdy_; r.rv = rv_; r.rdata = rdata_; r.en = en_; r.we = we_; r.mout = mout_;
    return r;
  endfunction

  localparam logic [31:0] DA = 32'hA000_0100;
  localparam logic [31:0] DB = 32'hB000_0200;

  initial begin
    vec_t tbl [22];
    logic [1:0] alt_exp [10];
    logic [1:0] rdy, rv;
    logic [31:0] rdat0, rdat1, mout;
    logic [11:0] maddr;
    logic en, we;
    int sel;

    // Expected behaviour of the MAX_BURST=4 instance, cycle by cycle.
    tbl[0]  = mk(1, 12'h010, 0, 0,                 0, 0, 0, 0,            2'b01, 2'b00, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,                       0, 0, 0, 0,            2'b00, 2'b01, 32'hDEADBEEF, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,                       1, 12'h020, 32'h12345678, 4'hF, 2'b10, 2'b00, 0, 1, 1, 32'h12345678);
    tbl[3]  = mk(0, 0, 0, 0,                       1, 12'h020, 0, 0,      2'b10, 2'b00, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,                       0, 0, 0, 0,            2'b00, 2'b10, 32'h12345678, 0, 0, 0);
    tbl[5]  = mk(1, 12'h040, 32'hAAAABBBB, 4'h3,   0, 0, 0, 0,            2'b01, 2'b00, 0, 1, 0, 0);
    tbl[6]  = mk(1, 12'h040, 0, 0,                 0, 0, 0, 0,            2'b00, 2'b00, 0, 1, 1, 32'h1122BBBB);
    tbl[7]  = mk(1, 12'h040, 0, 0,                 0, 0, 0, 0,            2'b01, 2'b00, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,                       0, 0, 0, 0,            2'b00, 2'b01, 32'h1122BBBB, 0, 0, 0);
    tbl[9]  = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b01, 2'b00, 0,  1, 0, 0);
    tbl[10] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b01, 2'b01, DA, 1, 0, 0);
    tbl[11] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b01, 2'b01, DA, 1, 0, 0);
    tbl[12] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b01, 2'b01, DA, 1, 0, 0);
    tbl[13] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b10, 2'b01, DA, 1, 0, 0);
    tbl[14] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b10, 2'b10, DB, 1, 0, 0);
    tbl[15] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b10, 2'b10, DB, 1, 0, 0);
    tbl[16] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b10, 2'b10, DB, 1, 0, 0);
    tbl[17] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b01, 2'b10, DB, 1, 0, 0);
    tbl[18] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b01, 2'b01, DA, 1, 0, 0);
    tbl[19] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b01, 2'b01, DA, 1, 0, 0);
    tbl[20] = mk(1, 12'h100, 0, 0, 1, 12'h200, 0, 0, 2'b01, 2'b01, DA, 1, 0, 0);
    tbl[21] = mk(0, 0, 0, 0,       0, 0, 0, 0,       2'b00, 2'b01, DA, 0, 0, 0);

    // MAX_BURST=1: m0 alone, six contested full writes, then m1 alone.
    alt_exp = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};

    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    v0 = 1'b1;
    #1;
    chk_zero(0, "in_reset");
    chk_zero(1, "in_reset");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    preload(12'h010, 32'hDEADBEEF);
    preload(12'h040, 32'h11223344);
    preload(12'h100, DA);
    preload(12'h200, DB);

    for (int i = 0; i < 22; i++) begin
      v0 = tbl[i].v0; a0 = tbl[i].a0; wd0 = tbl[i].wd0; ws0 = tbl[i].ws0;
      v1 = tbl[i].v1; a1 = tbl[i].a1; wd1 = tbl[i].wd1; ws1 = tbl[i].ws1;
      @(negedge clk);
      get_out(0, rdy, rv, rdat0, rdat1, en, we, mout, maddr);
      chk($sformatf("tbl%0d ready", i), 128'(rdy), 128'(tbl[i].rdy));
      chk($sformatf("tbl%0d rvalid", i), 128'(rv), 128'(tbl[i].rv));
      chk($sformatf("tbl%0d rdata0", i), 128'(rdat0), 128'(tbl[i].rv[0] ? tbl[i].rdata : 32'h0));
      chk($sformatf("tbl%0d rdata1", i), 128'(rdat1), 128'(tbl[i].rv[1] ? tbl[i].rdata : 32'h0));
      chk($sformatf("tbl%0d en_we", i), 128'({en, we}), 128'({tbl[i].en, tbl[i].we}));
      if (tbl[i].we) chk($sformatf("tbl%0d mem_out", i), 128'(mout), 128'(tbl[i].mout));
      tick();
    end

    for (int i = 0; i < 10; i++) begin
      idle();
      v0 = (i < 7); a0 = 12'h300; wd0 = 32'(i);         ws0 = 4'hF;
      v1 = (i >= 1); a1 = 12'h301; wd1 = 32'(100 + i);  ws1 = 4'hF;
      @(negedge clk);
      get_out(1, rdy, rv, rdat0, rdat1, en, we, mout, maddr);
      chk($sformatf("alt%0d ready", i), 128'(rdy), 128'(alt_exp[i]));
      tick();
    end

    // Reset landing in the MERGE cycle of a partial write must drop the write.
    preload(12'h030, 32'hCAFEF00D);
    v0 = 1'b1; a0 = 12'h030; wd0 = 32'h55555555; ws0 = 4'h1;
    step();
    idle();
    get_out(0, rdy, rv, rdat0, rdat1, en, we, mout, maddr);
    chk("merge_before_reset we", 128'({en, we}), 128'(2'b11));
    rst_n = 1'b0;
    #1;
    chk_zero(0, "merge_reset");
    chk_zero(1, "merge_reset");
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b1; a0 = 12'h030; ws0 = 4'h0;
    v1 = 1'b1; a1 = 12'h200; ws1 = 4'h0;
    @(negedge clk);
    get_out(0, rdy, rv, rdat0, rdat1, en, we, mout, maddr);
    chk("post_reset prio dut0", 128'(rdy), 128'(2'b01));
    get_out(1, rdy, rv, rdat0, rdat1, en, we, mout, maddr);
    chk("post_reset prio dut1", 128'(rdy), 128'(2'b01));
    tick();
    idle();
    @(negedge clk);
    chk("post_reset rdata 0x030", 128'(if4.m0_iob_rdata_o), 128'(32'hCAFEF00D));
    tick();

    for (int a = 0; a < 16; a++) preload(12'(a), 32'h0F0F_0000 + 32'(a));
    for (int n = 0; n < 400; n++) begin
      v0 = ($urandom_range(9) < 6);
      a0 = 12'($urandom_range(15)); wd0 = $urandom;
      sel = int'($urandom_range(2));
      ws0 = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(14, 1));
      v1 = ($urandom_range(9) < 6);
      a1 = 12'($urandom_range(15)); wd1 = $urandom;
      sel = int'($urandom_range(2));
      ws1 = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(14, 1));
      step();
    end
    idle();
    repeat (3) step();

    for (int a = 0; a < 16; a++) begin
      chk($sformatf("ram4[%0d]", a), 128'(ram4[a]), 128'(sh[0][a]));
      chk($sformatf("ram1[%0d]", a), 128'(ram1[a]), 128'(sh[1][a]));
    end
    chk("ram4[0x030] kept", 128'(ram4[12'h030]), 128'(32'hCAFEF00D));
    chk("ram1[0x030] kept", 128'(ram1[12'h030]), 128'(32'hCAFEF00D));
    chk("ram4[0x040] merged", 128'(ram4[12'h040]), 128'(32'h1122BBBB));
    chk("ram1[0x300]", 128'(ram1[12'h300]), 128'(sh[1][12'h300]));
    chk("ram1[0x301]", 128'(ram1[12'h301]), 128'(sh[1][12'h301]));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/iob_ext_dp_arbiter.md
Name: iob_ext_dp_arbiter

Overview:
- Shares one port of a Versat external dual-port RAM (ext_dp_* addr/out/in/enable/write bundle) between two IOb-native requesters, e.g. the Versat datapath and a CPU/debug window.
- Round-robin arbitration with a bounded burst allowance per master.
- Read-modify-write sequencing gives byte-strobed writes on a RAM port that only supports full-word writes.
- Memory read latency is fixed at 1 cycle.

Parameters:
- ADDR_W, 12, word address width of the RAM port.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_BURST, 4, maximum consecutive contested grants to one master before priority flips; must be >= 1.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous reset, active-low.
- m0_iob_valid_i  in  1  master 0 request.
- m0_iob_addr_i  in  ADDR_W  master 0 word address.
- m0_iob_wdata_i  in  DATA_W  master 0 write data.
- m0_iob_wstrb_i  in  DATA_W/8  master 0 byte strobes; 0 = read.
- m0_iob_ready_o  out  1  master 0 request accepted this cycle.
- m0_iob_rvalid_o  out  1  master 0 read data valid.
- m0_iob_rdata_o  out  DATA_W  master 0 read data.
- m1_iob_* (valid_i, addr_i, wdata_i, wstrb_i, ready_o, rvalid_o, rdata_o): identical set for master 1.
- mem_addr_o  out  ADDR_W  RAM address.
- mem_out_o  out  DATA_W  RAM write data.
- mem_in_i  in  DATA_W  RAM read data, valid the cycle after a read enable.
- mem_enable_o  out  1  RAM enable.
- mem_write_o  out  1  RAM write enable.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM to ARB; prio=0; cnt=0.
  - An in-flight RMW is dropped and no write is issued.
  - Reset is asynchronous assert, synchronous-safe deassert by the reset source.
- FSM states ARB and MERGE.
- ARB state:
  - Winner w:
    - If only one valid_i is high, that master wins.
    - If both are high, the master indexed by prio wins.
    - If neither is high, mem_enable_o=0.
  - Winner's ready_o=1, combinational, same cycle; loser's ready_o=0.
  - Access type is decided by wstrb:
    - wstrb==0 (read): mem_enable_o=1, mem_write_o=0, mem_addr_o=addr. Next cycle: mw_rvalid_o=1 (registered) and mw_rdata_o=mem_in_i.
    - wstrb all-ones (full write): mem_enable_o=1, mem_write_o=1, mem_out_o=wdata. No rvalid. Stay in ARB.
    - Partial wstrb: issue a read of addr (enable=1, write=0) and latch addr/wdata/wstrb/w. Go to MERGE.
- MERGE state (exactly 1 cycle):
  - Both ready_o=0.
  - mem_enable_o=1, mem_write_o=1, mem_addr_o=latched addr.
  - mem_out_o byte i = wstrb[i] ? wdata byte i : mem_in_i byte i.
  - No rvalid.
  - Return to ARB.
- Partial-write throughput: 2 cycles per partial write, 1 cycle per read or full write.
- Back-to-back accesses are allowed every cycle in ARB, including alternating masters.
- rdata_o is 0 whenever rvalid_o is 0.
- Priority update on each grant in ARB:
  - Contested (other master's valid_i also high) and cnt==MAX_BURST-1: prio<=other, cnt<=0.
  - Contested otherwise: prio<=w, cnt<=cnt+1.
  - Uncontested: prio<=w, cnt<=0.
  - MAX_BURST=1 yields strict alternation under contention.
- A master may drop valid_i before ready_o without side effects.
- Addr, wdata and wstrb are sampled only in the accept cycle.
- Only one rvalid_o can be high per cycle.
- A read issued the cycle after a write to the same address returns the written data (the RAM is write-then-read ordered per port).

Test Plan:
- Reset, then m0 reads addr 0x010 holding 0xDEADBEEF: ready same cycle, m0_rvalid 1 cycle later with 0xDEADBEEF, m1 outputs all 0.
- m1 full write 0x12345678 to 0x020 (wstrb=0xF), then read 0x020: mem_write_o=1 for one cycle; read returns 0x12345678.
- m0 partial write wstrb=0x3, wdata=0xAAAABBBB to a word holding 0x11223344: read cycle, then MERGE writes 0x1122BBBB; both ready_o low during MERGE; a subsequent read returns 0x1122BBBB.
- Both masters request reads continuously with MAX_BURST=4 from reset: grant order m0×4, m1×4, m0×4; each rvalid routed to the correct master with the correct data.
- MAX_BURST=1, both masters issuing full writes continuously: strict alternation m0,m1,m0,...; uncontested m1 requests (m0 idle) are granted every cycle.
- arst_n_i asserted during MERGE of a partial write to 0x030: no write reaches the RAM, 0x030 unchanged, all outputs 0 immediately; after release, priority resumes at m0.
